sig_change_monitor: RTL and testbench
=====================================

Name: sig_change_monitor

Overview:
- Parametrised, synthesizable monitor that watches NUM_CH single-bit status signals (LEDs, UART lines, etc.) and records each cycle in which an enabled channel changes.
- Each record holds a timestamped snapshot: changed-mask, new values and cycle count. Records are buffered in a FIFO and drained over a valid/ready stream, for example to a UART formatter or a simulation logger.
- Generalises per-cycle LED change printing with: channel count, edge filtering, enable masks, buffering, backpressure and drop accounting.

Parameters:
- NUM_CH, 3, number of monitored signals (1..32).
- TS_WIDTH, 32, timestamp counter width (8..64).
- FIFO_DEPTH, 16, event FIFO entries; power of two, >= 2.
- DROP_WIDTH, 16, width of the saturating dropped-event counter.

Ports:
- osc_clk  in  1  sole clock.
- osc_reset  in  1  synchronous, active-high reset.
- sig_in  in  NUM_CH  monitored signals, already synchronous to osc_clk.
- ch_enable  in  NUM_CH  per-channel enable; 0 masks the channel from triggering.
- edge_mode  in  2  0 = any change, 1 = rising only, 2 = falling only, 3 = any change.
- evt_valid  out  1  FIFO head holds a record.
- evt_ready  in  1  consumer accepts the head when evt_valid && evt_ready.
- evt_changed  out  NUM_CH  channels that qualified in this record.
- evt_value  out  NUM_CH  full sig_in snapshot, including non-changed and disabled bits.
- evt_timestamp  out  TS_WIDTH  cycle count at the sampling edge.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- drop_cnt  out  DROP_WIDTH  records lost to a full FIFO; saturating.

Behaviour:
- Reset (osc_reset high at an edge):
  - evt_valid = 0, fifo_level = 0, drop_cnt = 0, ts_cnt = 0, primed = 0.
  - evt_changed, evt_value and evt_timestamp = 0.
  - Reset mid-operation discards all queued records immediately.
- Timestamp: ts_cnt increments every non-reset edge. Its value is 0 at the first edge after reset deasserts. It wraps modulo 2^TS_WIDTH silently.
- Sampling stage, at every non-reset edge:
  - samp_q <= sig_in; ts_q <= ts_cnt; prev_q <= samp_q; primed <= 1.
  - First sample after reset is priming only. No record is made while primed = 0, so power-up values never generate events.
- Qualification, combinational on the registered values:
  - rise = samp_q & ~prev_q; fall = ~samp_q & prev_q.
  - sel = rise|fall, rise, fall or rise|fall according to edge_mode.
  - qual = sel & ch_enable.
  - push = primed && (qual != 0).
  - edge_mode and ch_enable are sampled combinationally in this cycle; a change applies to the next comparison.
- Record = {qual, samp_q, ts_q}. All simultaneous channel changes form exactly one record.
- Latency: sig_in is captured at edge k. The record is written at edge k+1, and evt_valid can first be high after edge k+1 (head is first-word-fall-through from registers). evt_timestamp reports the ts_cnt value at edge k−1.
- FIFO accept rule:
  - A push is accepted if fifo_level < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the record is discarded and drop_cnt increments, saturating at all-ones.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pop when empty is impossible because evt_valid = 0.
- Output stream:
  - Head fields are stable while evt_valid && !evt_ready.
  - After a pop, the next entry is presented the following cycle with no bubble.
  - evt_valid falls the cycle after the last pop.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; the level counter disambiguates full from empty.
- No combinational path exists from evt_ready to evt_valid or the data outputs.

Decomposition:
- Package sig_mon_pkg holds:
  - EDGE_ANY/EDGE_RISE/EDGE_FALL localparams.
  - Record field-width helper functions (clog2-based level width).
  - Record struct typedef built from NUM_CH/TS_WIDTH.
- One sub-module, sig_mon_fifo: synchronous FWFT FIFO parametrised by WIDTH and DEPTH, with push/pop/level/full/empty.
- Capture, qualification, timestamp and drop counter live in sig_change_monitor.

Test Plan:
- Prime: reset, hold sig_in = 3'b101 for 10 cycles → evt_valid stays 0 and drop_cnt = 0. The power-up value produces no record.
- Single change: NUM_CH = 3, edge_mode = 0, ch_enable = 3'b111; flip sig_in[1] 0→1 at cycle 20, evt_ready = 1 → one record: evt_changed = 3'b010, evt_value = new snapshot, evt_timestamp = 19; evt_valid high exactly 1 cycle.
- Simultaneous and edge filter: edge_mode = 1; sig_in 3'b011 → 3'b100 in one cycle → one record with evt_changed = 3'b100. Repeat with edge_mode = 2 → evt_changed = 3'b011. With ch_enable = 3'b000 → no record.
- Backpressure and full: FIFO_DEPTH = 4, evt_ready = 0; toggle sig_in[0] every cycle for 6 cycles → fifo_level = 4, drop_cnt = 2. Then raise evt_ready → 4 records with strictly increasing timestamps, unchanged while stalled.
- Push and pop when full: level = 4, evt_ready = 1 and a new change in the same cycle → level stays 4, drop_cnt unchanged. Saturation: DROP_WIDTH = 2 with 5 drops → drop_cnt = 3.
- Reset mid-stream and wrap: level = 3, assert osc_reset for 1 cycle → evt_valid = 0 and level = 0 next cycle, then priming again. With TS_WIDTH = 8, a change at ts 255 followed by one at ts 1 → timestamps 255 and 1 (wrap).

Source files
------------

// File: rtl/sig_mon_pkg.sv
// Shared constants and width helpers for the signal change monitor.
// Edge-mode encodings plus the field-width arithmetic used by the top and its FIFO.
package sig_mon_pkg;

    localparam logic [1:0] EDGE_ANY  = 2'd0;
    localparam logic [1:0] EDGE_RISE = 2'd1;
    localparam logic [1:0] EDGE_FALL = 2'd2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so a full FIFO is distinguishable from an empty one.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int rec_w(input int num_ch, input int ts_width);
        return 2 * num_ch + ts_width;
    endfunction

endpackage

// File: rtl/sig_mon_if.sv
// Event record stream: valid/ready handshake carrying one change record.
interface sig_mon_if #(
    parameter int NUM_CH   = 3,
    parameter int TS_WIDTH = 32
) ();

    logic                evt_valid;
    logic                evt_ready;
    logic [NUM_CH-1:0]   evt_changed;
    logic [NUM_CH-1:0]   evt_value;
    logic [TS_WIDTH-1:0] evt_timestamp;

    modport master (
        output evt_valid,
        output evt_changed,
        output evt_value,
        output evt_timestamp,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_changed,
        input  evt_value,
        input  evt_timestamp,
        output evt_ready
    );

endinterface

// File: rtl/sig_mon_fifo.sv
// Synchronous first-word-fall-through FIFO; the head is read straight from the
// register array and forced to zero while empty.
module sig_mon_fifo
    import sig_mon_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  logic [WIDTH-1:0]          din,
    output logic [WIDTH-1:0]          dout,
    output logic [level_w(DEPTH)-1:0] level,
    output logic                      full,
    output logic                      empty
);

    localparam int PW = ptr_w(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sig_change_monitor.sv
// Watches NUM_CH status lines and queues one timestamped record per cycle in
// which any enabled channel changes, with drop accounting when the queue is full.
module sig_change_monitor
    import sig_mon_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int TS_WIDTH   = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_WIDTH = 16
) (
    input  logic                           osc_clk,
    input  logic                           osc_reset,
    input  logic [NUM_CH-1:0]              sig_in,
    input  logic [NUM_CH-1:0]              ch_enable,
    input  logic [1:0]                     edge_mode,
    sig_mon_if.master                      evt,
    output logic [level_w(FIFO_DEPTH)-1:0] fifo_level,
    output logic [DROP_WIDTH-1:0]          drop_cnt
);

    localparam int RW = rec_w(NUM_CH, TS_WIDTH);

    typedef struct packed {
        logic [NUM_CH-1:0]   changed;
        logic [NUM_CH-1:0]   value;
        logic [TS_WIDTH-1:0] ts;
    } rec_t;

    logic [NUM_CH-1:0]   samp_q;
    logic [NUM_CH-1:0]   prev_q;
    logic [TS_WIDTH-1:0] ts_cnt;
    logic [TS_WIDTH-1:0] ts_q;
    logic                primed;
    logic [NUM_CH-1:0]   rise;
    logic [NUM_CH-1:0]   fall;
    logic [NUM_CH-1:0]   sel;
    logic [NUM_CH-1:0]   qual;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    rec_t                rec_in;
    rec_t                rec_out;

    // On the priming edge prev_q takes the same sample as samp_q, so the
    // power-up value is compared against itself and never raises a record.
    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            samp_q <= '0;
            prev_q <= '0;
            ts_cnt <= '0;
            ts_q   <= '0;
            primed <= 1'b0;
        end else begin
            samp_q <= sig_in;
            prev_q <= primed ? samp_q : sig_in;
            ts_q   <= ts_cnt;
            ts_cnt <= ts_cnt + 1'b1;
            primed <= 1'b1;
        end
    end

    always_comb begin
        rise = samp_q & ~prev_q;
        fall = ~samp_q & prev_q;
        case (edge_mode)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            default:   sel = rise | fall;
        endcase
        qual = sel & ch_enable;
        push = primed && (qual != '0);
    end

    assign rec_in = '{changed: qual, value: samp_q, ts: ts_q};
    assign pop    = evt.evt_valid && evt.evt_ready;

    sig_mon_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (osc_clk),
        .rst   (osc_reset),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .level (fifo_level),
        .full  (full),
        .empty (empty)
    );

    assign evt.evt_valid     = !empty;
    assign evt.evt_changed   = rec_out.changed;
    assign evt.evt_value     = rec_out.value;
    assign evt.evt_timestamp = rec_out.ts;

    // Counts records refused by a full FIFO; holds at all-ones.
    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            drop_cnt <= '0;
        end else if (push && full && !pop && (drop_cnt != {DROP_WIDTH{1'b1}})) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sig_change_monitor.sv
// Scoreboard bench for sig_change_monitor: tasks queue the records each change
// should produce and a negedge monitor checks every record the DUT hands over.
module tb_sig_change_monitor;
    import sig_mon_pkg::*;

    localparam int NUM_CH     = 3;
    localparam int TS_WIDTH   = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int DROP_WIDTH = 2;
    localparam int LW         = 3;

    typedef struct packed {
        logic [NUM_CH-1:0]   changed;
        logic [NUM_CH-1:0]   value;
        logic [TS_WIDTH-1:0] ts;
    } rec_t;

    logic                  osc_clk = 1'b0;
    logic                  osc_reset;
    logic [NUM_CH-1:0]     sig_in;
    logic [NUM_CH-1:0]     ch_enable;
    logic [1:0]            edge_mode;
    logic [LW-1:0]         fifo_level;
    logic [DROP_WIDTH-1:0] drop_cnt;

    int   tests_run    = 0;
    int   tests_failed = 0;
    rec_t exp_q[$];
    rec_t mon_exp;
    logic [TS_WIDTH-1:0] ts_model;
    logic [NUM_CH-1:0]   cur_sig;

    sig_mon_if #(.NUM_CH(NUM_CH), .TS_WIDTH(TS_WIDTH)) evt_bus ();

    sig_change_monitor #(
        .NUM_CH     (NUM_CH),
        .TS_WIDTH   (TS_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .DROP_WIDTH (DROP_WIDTH)
    ) dut (
        .osc_clk    (osc_clk),
        .osc_reset  (osc_reset),
        .sig_in     (sig_in),
        .ch_enable  (ch_enable),
        .edge_mode  (edge_mode),
        .evt        (evt_bus),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt)
    );

    always #5 osc_clk = ~osc_clk;

    // Reference cycle counter: the value held here when a sample is taken is its timestamp.
    always @(posedge osc_clk) begin
        ts_model <= osc_reset ? '0 : ts_model + 1'b1;
    end

    always @(negedge osc_clk) begin
        if (!osc_reset && evt_bus.evt_valid === 1'b1 && evt_bus.evt_ready === 1'b1) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL unexpected_record: got changed=%b value=%b ts=%0d, required no record",
                         evt_bus.evt_changed, evt_bus.evt_value, evt_bus.evt_timestamp);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({evt_bus.evt_changed, evt_bus.evt_value, evt_bus.evt_timestamp} !== mon_exp) begin
                    tests_failed++;
                    $display("[TB] FAIL record: got changed=%b value=%b ts=%0d, required changed=%b value=%b ts=%0d",
                             evt_bus.evt_changed, evt_bus.evt_value, evt_bus.evt_timestamp,
                             mon_exp.changed, mon_exp.value, mon_exp.ts);
                end
            end
        end
    end

    function automatic logic [NUM_CH-1:0] exp_qual(input logic [NUM_CH-1:0] old_v,
                                                   input logic [NUM_CH-1:0] new_v,
                                                   input logic [1:0] mode,
                                                   input logic [NUM_CH-1:0] en);
        logic [NUM_CH-1:0] r;
        logic [NUM_CH-1:0] f;
        r = new_v & ~old_v;
        f = ~new_v & old_v;
        if (mode == EDGE_RISE)      return r & en;
        else if (mode == EDGE_FALL) return f & en;
        else                        return (r | f) & en;
    endfunction

    task automatic tick();
        @(posedge osc_clk);
        #2;
    endtask

    task automatic drive_sig(input logic [NUM_CH-1:0] v, input bit accept);
        logic [NUM_CH-1:0] q;
        q = exp_qual(cur_sig, v, edge_mode, ch_enable);
        if (q != '0 && accept) begin
            exp_q.push_back(rec_t'{changed: q, value: v, ts: ts_model});
        end
        sig_in  = v;
        cur_sig = v;
        tick();
    endtask

    task automatic wait_drain(input string name);
        int n;
        tick();
        tick();
        evt_bus.evt_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || evt_bus.evt_valid !== 1'b0) && n < 40) begin
            tick();
            n++;
        end
        tests_run++;
        if (exp_q.size() != 0 || evt_bus.evt_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s_drain: got %0d records outstanding valid=%b, required 0 and 0",
                     name, exp_q.size(), evt_bus.evt_valid);
        end
    endtask

    task automatic check_counts(input string name, input logic [LW-1:0] lvl,
                                input logic [DROP_WIDTH-1:0] drops);
        tests_run++;
        if (fifo_level !== lvl) begin
            tests_failed++;
            $display("[TB] FAIL %s_level: got %0d, required %0d", name, fifo_level, lvl);
        end
        tests_run++;
        if (drop_cnt !== drops) begin
            tests_failed++;
            $display("[TB] FAIL %s_drop: got %0d, required %0d", name, drop_cnt, drops);
        end
    endtask

    task automatic test_reset();
        osc_reset         = 1'b1;
        sig_in            = 3'b101;
        cur_sig           = 3'b101;
        ch_enable         = 3'b111;
        edge_mode         = EDGE_ANY;
        evt_bus.evt_ready = 1'b0;
        tick();
        tick();
        tests_run++;
        if (evt_bus.evt_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_valid: got %b, required 0", evt_bus.evt_valid);
        end
        check_counts("reset", 3'd0, 2'd0);
        tests_run++;
        if ({evt_bus.evt_changed, evt_bus.evt_value, evt_bus.evt_timestamp} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_head: got changed=%b value=%b ts=%0d, required all zero",
                     evt_bus.evt_changed, evt_bus.evt_value, evt_bus.evt_timestamp);
        end
    endtask

    task automatic test_prime();
        int seen;
        seen      = 0;
        osc_reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (evt_bus.evt_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL prime_valid: got %0d valid cycles, required 0", seen);
        end
        check_counts("prime", 3'd0, 2'd0);
    endtask

    task automatic test_single_change();
        int seen;
        seen              = 0;
        evt_bus.evt_ready = 1'b1;
        drive_sig(3'b111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (evt_bus.evt_valid === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 1) begin
            tests_failed++;
            $display("[TB] FAIL single_valid_cycles: got %0d, required 1", seen);
        end
        wait_drain("single");
    endtask

    task automatic test_edge_filter();
        evt_bus.evt_ready = 1'b1;
        drive_sig(3'b011, 1'b1); tick();
        edge_mode = EDGE_RISE;
        drive_sig(3'b100, 1'b1); tick();
        edge_mode = EDGE_FALL;
        drive_sig(3'b011, 1'b1); tick();
        drive_sig(3'b100, 1'b1); tick();
        ch_enable = 3'b000;
        edge_mode = EDGE_ANY;
        drive_sig(3'b011, 1'b1); tick();
        drive_sig(3'b100, 1'b1); tick();
        ch_enable = 3'b111;
        edge_mode = 2'd3;
        drive_sig(3'b101, 1'b1); tick();
        edge_mode = EDGE_ANY;
        wait_drain("edge_filter");
    endtask

    task automatic test_backpressure();
        rec_t head;
        evt_bus.evt_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_sig(cur_sig ^ 3'b001, i < 4);
        end
        tick();
        tick();
        check_counts("backpressure", 3'd4, 2'd2);
        head = {evt_bus.evt_changed, evt_bus.evt_value, evt_bus.evt_timestamp};
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if ({evt_bus.evt_changed, evt_bus.evt_value, evt_bus.evt_timestamp} !== head
                || evt_bus.evt_valid !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL stall_head: got valid=%b ts=%0d, required valid=1 ts=%0d",
                         evt_bus.evt_valid, evt_bus.evt_timestamp, head.ts);
            end
        end
        wait_drain("backpressure");
    endtask

    task automatic test_push_pop_full();
        evt_bus.evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_sig(cur_sig ^ 3'b001, 1'b1);
        end
        tick();
        tick();
        check_counts("fill", 3'd4, 2'd2);
        drive_sig(cur_sig ^ 3'b010, 1'b1);
        evt_bus.evt_ready = 1'b1;
        tick();
        evt_bus.evt_ready = 1'b0;
        check_counts("push_pop_full", 3'd4, 2'd2);
        wait_drain("push_pop_full");
    endtask

    task automatic test_drop_saturate();
        evt_bus.evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            drive_sig(cur_sig ^ 3'b100, i < 4);
        end
        tick();
        tick();
        check_counts("saturate", 3'd4, 2'd3);
        wait_drain("saturate");
    endtask

    task automatic test_reset_midstream();
        int seen;
        seen              = 0;
        evt_bus.evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_sig(cur_sig ^ 3'b001, 1'b1);
        end
        tick();
        tick();
        check_counts("pre_reset", 3'd3, 2'd3);
        osc_reset = 1'b1;
        sig_in    = 3'b110;
        cur_sig   = 3'b110;
        tick();
        exp_q.delete();
        tests_run++;
        if (evt_bus.evt_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_valid: got %b, required 0", evt_bus.evt_valid);
        end
        check_counts("midreset", 3'd0, 2'd0);
        osc_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (evt_bus.evt_valid !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("[TB] FAIL reprime_valid: got %0d valid cycles, required 0", seen);
        end
        tests_run++;
        if (ts_model !== 8'd4) begin
            tests_failed++;
            $display("[TB] FAIL reprime_ts: got %0d, required 4", ts_model);
        end
        drive_sig(3'b111, 1'b1);
        wait_drain("reprime");
    endtask

    task automatic test_ts_wrap();
        int n;
        n                 = 0;
        evt_bus.evt_ready = 1'b1;
        while (ts_model !== 8'd255 && n < 300) begin
            tick();
            n++;
        end
        tests_run++;
        if (ts_model !== 8'd255) begin
            tests_failed++;
            $display("[TB] FAIL wrap_wait: got ts %0d, required 255", ts_model);
        end
        drive_sig(cur_sig ^ 3'b001, 1'b1);
        tick();
        tests_run++;
        if (ts_model !== 8'd1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_ts: got %0d, required 1", ts_model);
        end
        drive_sig(cur_sig ^ 3'b001, 1'b1);
        wait_drain("wrap");
    endtask

    initial begin
        test_reset();
        test_prime();
        test_single_change();
        test_edge_filter();
        test_backpressure();
        test_push_pop_full();
        test_drop_saturate();
        test_reset_midstream();
        test_ts_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish by 200000, required earlier finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
